fifo_axis_src: RTL and testbench

//  Read-side drain for the dual-clock FIFO: pops words from its read port and presents them as an AXI-Stream master.

---
 rtl/axis_pkg.sv | 28 ++
 rtl/axis_skid_buf.sv | 95 +++++++++
 rtl/fifo_axis_src.sv | 81 ++++++++
 tb/tb_fifo_axis_src.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the FIFO read-side AXI-Stream source.
//   buf_state_e : occupancy of the two-entry output buffer
//   clog2       : elaboration-time ceil(log2) used to size the beat counter
// -----------------------------------------------------------------------------
package axis_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// -----------------------------------------------------------------------------
// axis_skid_buf
// Two-entry valid/ready buffer. buf0 is the head and drives out_data; buf1
// is the skid entry that absorbs one word when the sink stalls. in_ready
// depends only on registered state, so the sink's ready never reaches the
// upstream pop combinationally.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   in_valid   in   upstream word available
//   in_ready   out  buffer can take a word this cycle (state != TWO)
//   in_data    in   upstream word
//   out_valid  out  head word valid (state != EMPTY)
//   out_ready  in   sink accepts head word
//   out_data   out  head word (buf0)
// -----------------------------------------------------------------------------
module axis_skid_buf
  import axis_pkg::*;
#(
  parameter int DSIZE = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data
);

  buf_state_e       state_q, state_d;
  logic [DSIZE-1:0] buf0_q, buf0_d;
  logic [DSIZE-1:0] buf1_q, buf1_d;
  logic             push;
  logic             pull;

  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = buf0_q;

  assign push = in_valid && in_ready;
  assign pull = out_valid && out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          buf0_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pull) begin
          buf0_d = in_data;
        end else if (push) begin
          buf1_d  = in_data;
          state_d = ST_TWO;
        end else if (pull) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // No push is possible here; only the skid entry moves up.
        if (pull) begin
          buf0_d  = buf1_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the data registers are reset too, not just the state, because
    // buf0 drives m_tdata directly and must read zero while in reset.
    if (rst) begin
      state_q <= ST_EMPTY;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state, so every flop samples
      // the values from before this edge regardless of statement order.
      state_q <= state_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

endmodule

// File: rtl/fifo_axis_src.sv
// -----------------------------------------------------------------------------
// fifo_axis_src
// Read-side drain for the dual-clock FIFO: pops words from the FIFO read port
// and presents them as an AXI-Stream master in the read clock domain. A fixed
// packet length drives m_tlast.
// Ports:
//   rclk      in   read-domain clock
//   rrst      in   synchronous active-high reset
//   rdata     in   FIFO head word, valid whenever rempty=0
//   rempty    in   FIFO empty flag
//   rinc      out  FIFO pop strobe
//   m_tdata   out  stream data
//   m_tvalid  out  stream valid
//   m_tready  in   stream ready
//   m_tlast   out  last beat of a PKT_LEN-beat packet
// -----------------------------------------------------------------------------
module fifo_axis_src
  import axis_pkg::*;
#(
  parameter int DSIZE   = 32,
  parameter int PKT_LEN = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic [DSIZE-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast
);

  localparam int            CW       = clog2((PKT_LEN > 1) ? PKT_LEN : 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(PKT_LEN - 1);

  logic          in_valid;
  logic          in_ready;
  logic          hs;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pop depends on rempty and registered buffer state only; m_tready is
  // deliberately absent so there is no ready-to-rinc combinational path.
  assign in_valid = !rempty && !rrst;
  assign rinc     = in_valid && in_ready;

  axis_skid_buf #(
    .DSIZE (DSIZE)
  ) u_skid (
    .clk       (rclk),
    .rst       (rrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (rdata),
    .out_valid (m_tvalid),
    .out_ready (m_tready),
    .out_data  (m_tdata)
  );

  assign hs = m_tvalid && m_tready;

  // Beat counter lives on the stream side, so an empty FIFO mid-packet
  // simply pauses the packet instead of ending it.
  always_comb begin
    cnt_d = cnt_q;
    if (hs) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign m_tlast = m_tvalid && (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_fifo_axis_src.sv
// -----------------------------------------------------------------------------
// tb_fifo_axis_src
// Drives fifo_axis_src from a queue-based FIFO model and checks the stream
// against an occupancy/scoreboard reference. A second instance built with
// PKT_LEN=1 checks the single-beat-packet case.
// -----------------------------------------------------------------------------
module tb_fifo_axis_src;

  localparam int DSIZE   = 32;
  localparam int PKT_LEN = 16;

  logic             rclk;
  logic             rrst;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic [DSIZE-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;

  logic             rrst1;
  logic [DSIZE-1:0] rdata1;
  logic             rempty1;
  logic             rinc1;
  logic [DSIZE-1:0] m_tdata1;
  logic             m_tvalid1;
  logic             m_tready1;
  logic             m_tlast1;

  fifo_axis_src #(.DSIZE(DSIZE), .PKT_LEN(PKT_LEN)) u_dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .rdata    (rdata),
    .rempty   (rempty),
    .rinc     (rinc),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast)
  );

  fifo_axis_src #(.DSIZE(DSIZE), .PKT_LEN(1)) u_dut1 (
    .rclk     (rclk),
    .rrst     (rrst1),
    .rdata    (rdata1),
    .rempty   (rempty1),
    .rinc     (rinc1),
    .m_tdata  (m_tdata1),
    .m_tvalid (m_tvalid1),
    .m_tready (m_tready1),
    .m_tlast  (m_tlast1)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int compared;
  int mismatched;

  // Reference model: FIFO contents, words inside the DUT in order, and the
  // number of handshakes since reset modulo the packet length.
  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] exp_q[$];
  int               occ;
  int               beat_cnt;
  bit               model_valid;

  // Samples from the most recent cycle.
  logic             s_rinc;
  logic             s_valid;
  logic             s_last;
  logic             s_hs;
  logic [DSIZE-1:0] s_data;

  // One rclk cycle: drive on the falling edge, sample 1 ns later, check
  // against the model, then advance the model across the rising edge.
  task automatic cycle(input logic rst_in, input logic rdy_in);
    bit exp_pop;
    @(negedge rclk);
    rrst     = rst_in;
    m_tready = rdy_in;
    rempty   = (fifo_q.size() == 0);
    if (fifo_q.size() != 0) rdata = fifo_q[0];
    else                    rdata = $urandom();
    #1;
    s_rinc  = rinc;
    s_valid = m_tvalid;
    s_data  = m_tdata;
    s_last  = m_tlast;
    s_hs    = m_tvalid && m_tready;
    exp_pop = !rempty && !rst_in && (occ < 2);
    if (model_valid) begin
      compared++;
      if (rinc !== exp_pop) begin
        mismatched++;
        $display("FAIL rinc: got %b expected %b (rempty=%b occ=%0d)", rinc, exp_pop, rempty, occ);
      end
      compared++;
      if (m_tvalid !== (occ > 0)) begin
        mismatched++;
        $display("FAIL tvalid: got %b expected %b", m_tvalid, (occ > 0));
      end
      if (occ > 0) begin
        compared++;
        if (m_tdata !== exp_q[0]) begin
          mismatched++;
          $display("FAIL tdata: got %h expected %h", m_tdata, exp_q[0]);
        end
        compared++;
        if (m_tlast !== (beat_cnt == PKT_LEN - 1)) begin
          mismatched++;
          $display("FAIL tlast: got %b expected %b (beat %0d)", m_tlast, (beat_cnt == PKT_LEN - 1), beat_cnt);
        end
      end else begin
        compared++;
        if (m_tlast !== 1'b0) begin
          mismatched++;
          $display("FAIL tlast_idle: got %b expected 0", m_tlast);
        end
      end
    end
    @(posedge rclk);
    if (rst_in) begin
      exp_q.delete();
      occ         = 0;
      beat_cnt    = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (occ > 0 && rdy_in) begin
        void'(exp_q.pop_front());
        occ--;
        beat_cnt = (beat_cnt + 1) % PKT_LEN;
      end
      if (exp_pop) begin
        exp_q.push_back(fifo_q.pop_front());
        occ++;
      end
    end
  endtask

  task automatic do_reset();
    fifo_q.delete();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
  endtask

  task automatic test_reset();
    fifo_q.delete();
    for (int i = 0; i < 8; i++) fifo_q.push_back(32'h0000_0050 + i);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1);
      if (i >= 1) begin
        compared++;
        if (s_rinc !== 1'b0 || s_valid !== 1'b0 || s_last !== 1'b0 || s_data !== '0) begin
          mismatched++;
          $display("FAIL reset_outputs: got rinc=%b tvalid=%b tlast=%b tdata=%h expected all 0",
                   s_rinc, s_valid, s_last, s_data);
        end
      end
    end
    cycle(1'b0, 1'b0);
    compared++;
    if (s_rinc !== 1'b1) begin
      mismatched++;
      $display("FAIL first_rinc: got %b expected 1", s_rinc);
    end
    cycle(1'b0, 1'b0);
    compared++;
    if (s_valid !== 1'b1 || s_data !== 32'h0000_0050) begin
      mismatched++;
      $display("FAIL first_word: got tvalid=%b tdata=%h expected 1 / 00000050", s_valid, s_data);
    end
  endtask

  task automatic test_streaming();
    int nbeats;
    int first_cyc;
    int last_cyc;
    do_reset();
    for (int i = 0; i < 32; i++) fifo_q.push_back(i);
    nbeats    = 0;
    first_cyc = -1;
    last_cyc  = -1;
    for (int c = 0; c < 40; c++) begin
      cycle(1'b0, 1'b1);
      if (s_hs) begin
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        compared++;
        if (s_data !== nbeats) begin
          mismatched++;
          $display("FAIL stream_data: got %h expected %h", s_data, nbeats);
        end
        compared++;
        if (s_last !== (nbeats == 15 || nbeats == 31)) begin
          mismatched++;
          $display("FAIL stream_last: got %b at word %h", s_last, s_data);
        end
        nbeats++;
      end
    end
    compared++;
    if (nbeats != 32 || first_cyc != 1 || last_cyc - first_cyc != 31) begin
      mismatched++;
      $display("FAIL stream_rate: got %0d beats in cycles %0d..%0d expected 32 in 1..32",
               nbeats, first_cyc, last_cyc);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 20; i++) fifo_q.push_back(32'h0000_0100 + i);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0);
      compared++;
      if (s_valid !== 1'b1 || s_data !== 32'h0000_0101) begin
        mismatched++;
        $display("FAIL bp_stable: got tvalid=%b tdata=%h expected 1 / 00000101", s_valid, s_data);
      end
    end
    compared++;
    if (s_rinc !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_rinc: got %b expected 0 while stalled full", s_rinc);
    end
    for (int i = 0; i < 19; i++) begin
      cycle(1'b0, 1'b1);
      compared++;
      if (s_hs !== 1'b1 || s_data !== 32'h0000_0101 + i) begin
        mismatched++;
        $display("FAIL bp_resume: got hs=%b tdata=%h expected 1 / %h", s_hs, s_data, 32'h0000_0101 + i);
      end
    end
  endtask

  task automatic test_random();
    logic [DSIZE-1:0] sent_q[$];
    logic [DSIZE-1:0] w;
    int               n_sent;
    int               rcv;
    do_reset();
    n_sent = 0;
    rcv    = 0;
    for (int c = 0; c < 10000 && rcv < 1000; c++) begin
      if (n_sent < 1000 && $urandom_range(0, 99) < 60) begin
        w = $urandom();
        fifo_q.push_back(w);
        sent_q.push_back(w);
        n_sent++;
      end
      cycle(1'b0, 1'($urandom_range(0, 1)));
      if (s_hs) begin
        compared++;
        if (s_data !== sent_q[rcv]) begin
          mismatched++;
          $display("FAIL rand_order: beat %0d got %h expected %h", rcv, s_data, sent_q[rcv]);
        end
        rcv++;
      end
    end
    compared++;
    if (rcv != 1000) begin
      mismatched++;
      $display("FAIL rand_count: got %0d words expected 1000", rcv);
    end
  endtask

  task automatic test_mid_reset();
    int nbeats;
    int first_last;
    do_reset();
    for (int i = 0; i < 40; i++) fifo_q.push_back(32'h0000_0200 + i);
    nbeats = 0;
    for (int c = 0; c < 20 && nbeats < 5; c++) begin
      cycle(1'b0, 1'b1);
      if (s_hs) nbeats++;
    end
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    compared++;
    if (s_valid !== 1'b0 || s_last !== 1'b0 || s_data !== '0) begin
      mismatched++;
      $display("FAIL mid_reset_clear: got tvalid=%b tlast=%b tdata=%h expected 0", s_valid, s_last, s_data);
    end
    nbeats     = 0;
    first_last = 0;
    for (int c = 0; c < 60 && first_last == 0; c++) begin
      cycle(1'b0, 1'b1);
      if (s_hs) begin
        nbeats++;
        if (s_last) first_last = nbeats;
      end
    end
    compared++;
    if (first_last != 16) begin
      mismatched++;
      $display("FAIL mid_reset_tlast: got first tlast on beat %0d expected 16", first_last);
    end
  endtask

  task automatic test_pkt_len1();
    logic [DSIZE-1:0] q1[$];
    int               idx;
    bit               pop;
    for (int i = 0; i < 4; i++) q1.push_back(32'h0000_00A0 + i);
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge rclk);
      rrst1     = (c < 2);
      m_tready1 = 1'b1;
      rempty1   = (q1.size() == 0);
      if (q1.size() != 0) rdata1 = q1[0];
      #1;
      if (c >= 2 && m_tvalid1 && m_tready1) begin
        compared++;
        if (m_tlast1 !== 1'b1 || m_tdata1 !== 32'h0000_00A0 + idx) begin
          mismatched++;
          $display("FAIL len1_beat: got tlast=%b tdata=%h expected 1 / %h", m_tlast1, m_tdata1, 32'h0000_00A0 + idx);
        end
        idx++;
      end
      pop = (c >= 2) && (rinc1 === 1'b1) && (q1.size() != 0);
      @(posedge rclk);
      if (pop) void'(q1.pop_front());
    end
    compared++;
    if (idx != 4) begin
      mismatched++;
      $display("FAIL len1_count: got %0d beats expected 4", idx);
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    occ         = 0;
    beat_cnt    = 0;
    model_valid = 1'b0;
    rrst        = 1'b1;
    rempty      = 1'b1;
    rdata       = '0;
    m_tready    = 1'b0;
    rrst1       = 1'b1;
    rempty1     = 1'b1;
    rdata1      = '0;
    m_tready1   = 1'b0;

    test_reset();
    test_streaming();
    test_backpressure();
    test_random();
    test_mid_reset();
    test_pkt_len1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
